// File: rtl/uart_defs.sv
// Shared definitions for the UART transmitter arbiter: FSM states, default
// busy timeout and requester index assignments.
`default_nettype none

package uart_defs;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_WAIT_BUSY = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } arb_state_t;

    localparam int BUSY_TIMEOUT_DEFAULT = 64;

    localparam int REQ_GOLD = 0;
    localparam int REQ_TIME = 1;
    localparam int REQ_CMD  = 2;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshake plus the transmitter en/data/rdy link.
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic                 tx_rdy;

    modport master (
        output req_valid, req_data, req_last, tx_rdy,
        input  req_ready, tx_en, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_rdy,
        output req_ready, tx_en, tx_data
    );
endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after the pointer,
// wrapping. Pointer tied to NUM_REQ-1 gives lowest-index-first priority.
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   pointer,
    output logic [PTR_W-1:0]   winner,
    output logic               found
);

    logic [PTR_W-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        w_idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = PTR_W'((int'(pointer) + k) % NUM_REQ);
            if (eligible[w_idx]) begin
                winner = w_idx;
                found  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter between NUM_REQ byte producers,
//               with per-requester message lock and busy-timeout recovery.
//               Define TXARB_FIXED_PRIO_EN for fixed (lowest index) priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_defs::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_arbiter_if.slave    bus,
    output logic [NUM_REQ-1:0]  grant,
    output logic                busy,
    output logic                err_timeout
);

    localparam int               PTR_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] C_LAST_IDX    = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_MAX = CNT_W'(BUSY_TIMEOUT - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_ready, w_ready_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic               r_tx_en, w_tx_en_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic               r_lock, w_lock_nxt;
    logic               r_err, w_err_nxt;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0] w_eligible;
    logic [PTR_W-1:0]   w_ptr;
    logic [PTR_W-1:0]   w_winner;
    logic               w_found;

    // While locked the current grant is the holder; nobody else may compete.
    assign w_eligible = r_lock ? (bus.req_valid & r_grant) : bus.req_valid;

`ifdef TXARB_FIXED_PRIO_EN
    assign w_ptr = C_LAST_IDX;
`else
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= C_LAST_IDX;
        end else if (w_tx_en_nxt) begin
            r_ptr <= w_winner;
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .eligible (w_eligible),
        .pointer  (w_ptr),
        .winner   (w_winner),
        .found    (w_found)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ready_nxt   = '0;
        w_tx_en_nxt   = 1'b0;
        w_tx_data_nxt = r_tx_data;
        w_grant_nxt   = r_grant;
        w_lock_nxt    = r_lock;
        w_err_nxt     = 1'b0;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (bus.tx_rdy && w_found) begin
                    w_ready_nxt[w_winner] = 1'b1;
                    w_grant_nxt           = '0;
                    w_grant_nxt[w_winner] = 1'b1;
                    w_tx_data_nxt         = bus.req_data[{w_winner, 3'b000} +: 8];
                    w_tx_en_nxt           = 1'b1;
                    w_lock_nxt            = ~bus.req_last[w_winner];
                    w_cnt_nxt             = '0;
                    w_state_nxt           = ARB_WAIT_BUSY;
                end
            end
            ARB_WAIT_BUSY: begin
                if (!bus.tx_rdy) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ARB_WAIT_DONE;
                end else if (r_cnt == C_TIMEOUT_MAX) begin
                    // Transmitter never took the byte: drop it and free the link.
                    w_err_nxt   = 1'b1;
                    w_lock_nxt  = 1'b0;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ARB_WAIT_DONE: begin
                if (bus.tx_rdy) begin
                    w_state_nxt = ARB_IDLE;
                    if (!r_lock) begin
                        w_grant_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_ready   <= '0;
            r_tx_en   <= 1'b0;
            r_tx_data <= 8'h00;
            r_grant   <= '0;
            r_lock    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= w_ready_nxt;
            r_tx_en   <= w_tx_en_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_grant   <= w_grant_nxt;
            r_lock    <= w_lock_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= (w_state_nxt != ARB_IDLE) || w_lock_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.tx_en     = r_tx_en;
    assign bus.tx_data   = r_tx_data;
    assign grant         = r_grant;
    assign busy          = r_busy;
    assign err_timeout   = r_err;

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single PC-facing UART transmitter (uart_tx_sol instance driving TX) between several byte producers: gold-board echo, timing reporter, password dump, command echo and error codes. Each requester gets a valid/ready byte handshake. The arbiter drives the transmitter's en/data_in and tracks its rdy to pace bytes. A requester can lock the transmitter for a multi-byte message, so a timing string such as "$$#+..!" is never interleaved with echoed gold bytes.

Parameters:
NUM_REQ, 3, number of requesters (2..8); index 0 is the gold echo path.
BUSY_TIMEOUT, 64, max cycles after tx_en for tx_rdy to fall before the byte is declared lost.
CNT_W, 8, width of the busy-timeout counter; must satisfy 2^CNT_W > BUSY_TIMEOUT.

Ports:
clk  in  1  system clock (CLK of top).
rst_n  in  1  synchronous reset, active-low.
req_valid  in  NUM_REQ  requester i has a byte on req_data.
req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
req_last  in  NUM_REQ  byte i ends the requester's message; 0 keeps the lock.
req_ready  out  NUM_REQ  one-cycle pulse; byte of requester i accepted this cycle.
tx_en  out  1  to uart_tx_sol en; one-cycle pulse.
tx_data  out  8  to uart_tx_sol data_in; held stable until the next issue.
tx_rdy  in  1  from uart_tx_sol rdy.
grant  out  NUM_REQ  one-hot current owner or lock holder; 0 when free.
busy  out  1  high in any state other than IDLE, or while a lock is held.
err_timeout  out  1  one-cycle pulse when tx_rdy fails to fall within BUSY_TIMEOUT.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; req_ready=0; tx_en=0; tx_data=8'h00; grant=0; busy=0; err_timeout=0; lock cleared; RR pointer=NUM_REQ-1; timeout counter=0. Reset mid-byte abandons the byte silently; no req_ready is re-issued.
- All outputs are registered.
- IDLE:
  - Eligible set: only the lock holder if a lock is held, otherwise all req_valid.
  - If tx_rdy=1 and the eligible set is non-empty, pick winner w.
  - Same edge: req_ready[w]<=1, tx_data<=req_data[w], tx_en<=1, grant<=onehot(w), lock<=~req_last[w], RR pointer<=w, then go to WAIT_BUSY.
  - If tx_rdy=0, wait in IDLE. No acceptance happens.
- WAIT_BUSY: counter increments each cycle.
  - tx_rdy=0 → counter=0, go to WAIT_DONE.
  - counter reaches BUSY_TIMEOUT-1 with tx_rdy still 1 → err_timeout pulse, lock cleared, grant=0, go to IDLE. The byte counts as consumed.
- WAIT_DONE: tx_rdy=1 → IDLE. grant is held if the lock is still set, else grant<=0.
- This WAIT_BUSY/WAIT_DONE sequence replaces the ad-hoc wait_flag logic. A byte is never issued twice on one stale rdy.
- Accept latency: req_valid with the transmitter free and IDLE → req_ready and tx_en on the next edge. Minimum spacing between accepted bytes is 3 cycles plus the transmitter busy time.
- Round-robin arbitration: search starts at (RR pointer+1) mod NUM_REQ and wraps. The winner becomes the new pointer.
- Lock rules:
  - The lock is set by an accepted byte with req_last=0 and cleared by an accepted byte with req_last=1.
  - While locked, other requesters' req_valid are ignored, even if the holder is idle.
  - Holder dropping req_valid does not release the lock.
- Requesters must hold req_valid/req_data/req_last stable until req_ready. Valid deasserting without ready is legal (request withdrawn).
- At most one req_ready bit is high in any cycle.

Optional Feature:
TXARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority with the lowest index winning (gold echo 0 always first), and the RR pointer is removed. When undefined, round-robin as above. Lock behaviour is identical in both modes.

Decomposition:
- Shared package uart_defs: state encoding localparams (ARB_IDLE, ARB_WAIT_BUSY, ARB_WAIT_DONE), the default BUSY_TIMEOUT, and requester index constants (REQ_GOLD=0, REQ_TIME=1, REQ_CMD=2).
- One sub-module: rr_pick, a combinational one-hot picker with inputs eligible vector and pointer, output winner index plus found flag. Fixed priority is the same module with the pointer tied to NUM_REQ-1.

Test Plan:
- Single byte: req_valid[1]=1, data 8'h21 ("!"), last=1, tx_rdy=1 → next edge req_ready[1], tx_en, tx_data=8'h21. Model drops rdy 2 cycles later and raises it after 100 → exactly one tx_en, back to IDLE, grant=0.
- Round robin: all three valid continuously, each last=1 → accept order 0,1,2,0,1,2 over 6 bytes. With TXARB_FIXED_PRIO_EN → 0,0,0,... and requester 2 is never served.
- Lock: requester 1 sends "$","#","+" with last=0,0,1 while requester 0 is valid throughout → 3 consecutive grants to 1, then requester 0 is served next.
- Stuck transmitter: tx_rdy held at 1 after tx_en → err_timeout pulses exactly BUSY_TIMEOUT cycles later. State returns to IDLE, lock is cleared, the next pending requester is served.
- Back-pressure: tx_rdy=0 with requests pending → no req_ready and no tx_en until tx_rdy=1, then one issue.
- Reset mid-byte: rst_n=0 for 1 cycle during WAIT_DONE while a lock is held → all outputs at reset values, grant=0, lock cleared, arbitration restarts from requester 0.
